// File: rtl/axi_txn_timeout_tracker_pkg.sv
// Shared types and defaults for the AXI transaction timeout tracker.
// Holds the default geometry, the internal-ID / countdown types and the
// per-burst slot record. The register file reuses these for its flag and ID
// fields.
package axi_txn_timeout_tracker_pkg;

  localparam int unsigned MaxUniqIdsDef   = 32;
  localparam int unsigned MaxTxnsPerIdDef = 4;
  localparam int unsigned CntWidthDef     = 10;
  localparam int unsigned PrescalerDivDef = 64;

  // $clog2 that never returns 0, so a 1-entry range still gets a 1-bit index.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned IntIdWidthDef = clog2_min1(MaxUniqIdsDef);

  typedef logic [IntIdWidthDef-1:0] intid_t;
  typedef logic [CntWidthDef-1:0]   cnt_t;

  typedef struct packed {
    logic valid;
    logic expired;
    cnt_t cnt;
  } slot_t;

endpackage

// File: rtl/axi_txn_timeout_tracker_if.sv
// Snooped request/response handshake bundle seen by the timeout tracker.
//   req_valid/req_ready/req_id          : AW or AR handshake (internal ID)
//   rsp_valid/rsp_ready/rsp_last/rsp_id : B or R handshake (internal ID)
// master: whoever drives the bus; slave: the passive tracker (all inputs).
interface axi_txn_timeout_tracker_if #(
  parameter int unsigned IdWidth = 5
) ();
  logic               req_valid;
  logic               req_ready;
  logic [IdWidth-1:0] req_id;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_last;
  logic [IdWidth-1:0] rsp_id;

  modport master (
    output req_valid, req_ready, req_id,
    output rsp_valid, rsp_ready, rsp_last, rsp_id
  );

  modport slave (
    input req_valid, req_ready, req_id,
    input rsp_valid, rsp_ready, rsp_last, rsp_id
  );
endinterface

// File: rtl/axi_txn_timeout_tracker_txn_slot_queue.sv
// In-order queue of outstanding bursts for a single internal ID.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   push_i         request accepted for this ID
//   pop_i          last-beat response accepted for this ID
//   tick_i         prescaled tick; countdowns advance only here
//   budget_i       countdown loaded into a pushed slot
//   full_o/empty_o occupancy status (combinational from registered state)
//   fire_o         some slot hit zero on this tick (pulse)
//   overflow_o     push dropped because the queue was full (pulse)
//   unexp_o        pop while empty (pulse)
module txn_slot_queue
  import axi_txn_timeout_tracker_pkg::*;
#(
  parameter int unsigned Depth    = 4,
  parameter int unsigned CntWidth = 10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic                tick_i,
  input  logic [CntWidth-1:0] budget_i,
  output logic                full_o,
  output logic                empty_o,
  output logic                fire_o,
  output logic                overflow_o,
  output logic                unexp_o
);
  localparam int unsigned PtrWidth = clog2_min1(Depth);
  localparam int unsigned OccWidth = $clog2(Depth + 1);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

  typedef struct packed {
    logic                valid;
    logic                expired;
    logic [CntWidth-1:0] cnt;
  } slot_rec_t;

  slot_rec_t           slots_reg [Depth];
  logic [PtrWidth-1:0] head_reg, tail_reg;
  logic [OccWidth-1:0] occ_reg, occ_next;
  logic [Depth-1:0]    slot_fire;
  logic                do_push, do_pop;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (occ_reg == OccWidth'(Depth));
  assign empty_o = (occ_reg == '0);

  // A pop on a full queue frees the head in the same cycle, so a
  // simultaneous push is accepted even when full.
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || pop_i);
  assign overflow_o = push_i && full_o && !pop_i;
  assign unexp_o    = pop_i && empty_o;

  for (genvar gi = 0; gi < Depth; gi++) begin : g_fire
    assign slot_fire[gi] = slots_reg[gi].valid && !slots_reg[gi].expired &&
                           (slots_reg[gi].cnt == '0);
  end
  assign fire_o = tick_i && (|slot_fire);

  always_comb begin
    occ_next = occ_reg;
    case ({do_push, do_pop})
      2'b10:   occ_next = occ_reg + 1'b1;
      2'b01:   occ_next = occ_reg - 1'b1;
      default: occ_next = occ_reg;
    endcase
  end

  // Statement order matters: countdown first, then pop, then push, so a
  // freshly pushed slot (possibly reusing the popped head) is never ticked.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) slots_reg[i] <= '0;
      head_reg <= '0;
      tail_reg <= '0;
      occ_reg  <= '0;
    end else begin
      if (tick_i) begin
        for (int i = 0; i < Depth; i++) begin
          if (slots_reg[i].valid && !slots_reg[i].expired) begin
            if (slots_reg[i].cnt == '0) slots_reg[i].expired <= 1'b1;
            else                        slots_reg[i].cnt     <= slots_reg[i].cnt - 1'b1;
          end
        end
      end
      if (do_pop) begin
        slots_reg[head_reg] <= '0;
        head_reg            <= next_ptr(head_reg);
      end
      if (do_push) begin
        slots_reg[tail_reg] <= '{valid: 1'b1, expired: 1'b0, cnt: budget_i};
        tail_reg            <= next_ptr(tail_reg);
      end
      occ_reg <= occ_next;
    end
  end
endmodule

// File: rtl/axi_txn_timeout_tracker.sv
// Passive per-ID latency watchdog for one AXI direction (AW/B or AR/R).
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   enable_i       prescaler/countdowns run when 1; tracking always runs
//   clear_i        clears the sticky flags (not the queues)
//   budget_i       countdown loaded when a request is accepted
//   bus            snooped request/response handshakes (slave modport)
//   id_full_o      per-ID queue full
//   busy_o         any burst outstanding
//   timeout_o      sticky: a burst exceeded its budget
//   timeout_id_o   ID of the first latched timeout (lowest ID on that tick)
//   overflow_o     sticky: request dropped because its ID was full
//   unexp_rsp_o    sticky: last-beat response with nothing outstanding
module axi_txn_timeout_tracker
  import axi_txn_timeout_tracker_pkg::*;
#(
  parameter int unsigned MaxUniqIds   = MaxUniqIdsDef,
  parameter int unsigned MaxTxnsPerId = MaxTxnsPerIdDef,
  parameter int unsigned CntWidth     = CntWidthDef,
  parameter int unsigned PrescalerDiv = PrescalerDivDef,
  parameter int unsigned IntIdWidth   = clog2_min1(MaxUniqIds)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic [CntWidth-1:0]     budget_i,
  axi_txn_timeout_tracker_if.slave bus,
  output logic [MaxUniqIds-1:0]   id_full_o,
  output logic                    busy_o,
  output logic                    timeout_o,
  output logic [IntIdWidth-1:0]   timeout_id_o,
  output logic                    overflow_o,
  output logic                    unexp_rsp_o
);
  localparam int unsigned PreWidth = clog2_min1(PrescalerDiv);
  localparam logic [PreWidth-1:0] PreLast = PreWidth'(PrescalerDiv - 1);

  logic [PreWidth-1:0]   pre_reg;
  logic                  tick;
  logic                  req_hs, rsp_hs;
  logic [MaxUniqIds-1:0] empty, fire, ovf_evt, unexp_evt;
  logic                  fire_any;
  logic [IntIdWidth-1:0] fire_id;

  logic                  timeout_reg, timeout_next;
  logic [IntIdWidth-1:0] timeout_id_reg, timeout_id_next;
  logic                  overflow_reg, overflow_next;
  logic                  unexp_reg, unexp_next;

  // Prescaler: tick in the cycle the count sits at PrescalerDiv-1.
  assign tick = enable_i && (pre_reg == PreLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       pre_reg <= '0;
    else if (tick)     pre_reg <= '0;
    else if (enable_i) pre_reg <= pre_reg + 1'b1;
  end

  assign req_hs = bus.req_valid && bus.req_ready;
  assign rsp_hs = bus.rsp_valid && bus.rsp_ready && bus.rsp_last;

  for (genvar gi = 0; gi < MaxUniqIds; gi++) begin : g_id
    txn_slot_queue #(
      .Depth    (MaxTxnsPerId),
      .CntWidth (CntWidth)
    ) u_queue (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push_i     (req_hs && (bus.req_id == IntIdWidth'(gi))),
      .pop_i      (rsp_hs && (bus.rsp_id == IntIdWidth'(gi))),
      .tick_i     (tick),
      .budget_i   (budget_i),
      .full_o     (id_full_o[gi]),
      .empty_o    (empty[gi]),
      .fire_o     (fire[gi]),
      .overflow_o (ovf_evt[gi]),
      .unexp_o    (unexp_evt[gi])
    );
  end

  assign busy_o = ~&empty;

  // Lowest firing ID wins: scan downward so the smallest index is written last.
  always_comb begin
    fire_id  = '0;
    fire_any = |fire;
    for (int i = MaxUniqIds - 1; i >= 0; i--) begin
      if (fire[i]) fire_id = IntIdWidth'(i);
    end
  end

  // clear_i zeroes the flags, but an event in the same cycle re-sets them.
  always_comb begin
    timeout_next    = timeout_reg;
    timeout_id_next = timeout_id_reg;
    overflow_next   = overflow_reg;
    unexp_next      = unexp_reg;
    if (clear_i) begin
      timeout_next    = 1'b0;
      timeout_id_next = '0;
      overflow_next   = 1'b0;
      unexp_next      = 1'b0;
    end
    if (fire_any && (!timeout_reg || clear_i)) begin
      timeout_next    = 1'b1;
      timeout_id_next = fire_id;
    end
    if (|ovf_evt)   overflow_next = 1'b1;
    if (|unexp_evt) unexp_next    = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_reg    <= 1'b0;
      timeout_id_reg <= '0;
      overflow_reg   <= 1'b0;
      unexp_reg      <= 1'b0;
    end else begin
      timeout_reg    <= timeout_next;
      timeout_id_reg <= timeout_id_next;
      overflow_reg   <= overflow_next;
      unexp_reg      <= unexp_next;
    end
  end

  assign timeout_o    = timeout_reg;
  assign timeout_id_o = timeout_id_reg;
  assign overflow_o   = overflow_reg;
  assign unexp_rsp_o  = unexp_reg;
endmodule

// File: tb/tb_axi_txn_timeout_tracker.sv
// Directed self-checking bench for axi_txn_timeout_tracker
// (PrescalerDiv=4, MaxTxnsPerId=2). After each reset release the prescaler
// ticks on posedges 4, 8, 12, ... counted from the release.
module tb_axi_txn_timeout_tracker;
  localparam int unsigned MaxUniqIds   = 32;
  localparam int unsigned MaxTxnsPerId = 2;
  localparam int unsigned CntWidth     = 10;
  localparam int unsigned PrescalerDiv = 4;
  localparam int unsigned IntIdWidth   = 5;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic                  enable_i = 1'b1;
  logic                  clear_i = 1'b0;
  logic [CntWidth-1:0]   budget_i = '0;
  logic [MaxUniqIds-1:0] id_full_o;
  logic                  busy_o;
  logic                  timeout_o;
  logic [IntIdWidth-1:0] timeout_id_o;
  logic                  overflow_o;
  logic                  unexp_rsp_o;

  int n_cmp = 0;
  int n_bad = 0;

  axi_txn_timeout_tracker_if #(.IdWidth(IntIdWidth)) bus ();

  axi_txn_timeout_tracker #(
    .MaxUniqIds   (MaxUniqIds),
    .MaxTxnsPerId (MaxTxnsPerId),
    .CntWidth     (CntWidth),
    .PrescalerDiv (PrescalerDiv),
    .IntIdWidth   (IntIdWidth)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .enable_i     (enable_i),
    .clear_i      (clear_i),
    .budget_i     (budget_i),
    .bus          (bus),
    .id_full_o    (id_full_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o),
    .timeout_id_o (timeout_id_o),
    .overflow_o   (overflow_o),
    .unexp_rsp_o  (unexp_rsp_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-22s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic idle_bus();
    bus.req_valid = 1'b0;
    bus.req_ready = 1'b0;
    bus.req_id    = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.rsp_last  = 1'b0;
    bus.rsp_id    = '0;
  endtask

  task automatic set_req(input logic [IntIdWidth-1:0] id);
    bus.req_valid = 1'b1;
    bus.req_ready = 1'b1;
    bus.req_id    = id;
  endtask

  task automatic set_rsp(input logic [IntIdWidth-1:0] id, input logic last);
    bus.rsp_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.rsp_last  = last;
    bus.rsp_id    = id;
  endtask

  // Leaves the bench at posedge+1 with rst_ni released; next edge is edge 1.
  task automatic do_reset();
    rst_ni   = 1'b0;
    enable_i = 1'b1;
    clear_i  = 1'b0;
    idle_bus();
    step();
    step();
    rst_ni = 1'b1;
  endtask

  initial begin
    idle_bus();

    // 1: budget 3, single burst on ID5, never answered -> fires at edge 16.
    do_reset();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_timeout_id", 32'(timeout_id_o), 32'd0);
    chk("rst_overflow", 32'(overflow_o), 32'd0);
    chk("rst_unexp", 32'(unexp_rsp_o), 32'd0);
    chk("rst_id_full", id_full_o, 32'd0);
    $display("txn: push id5 budget3");
    budget_i = 10'd3;
    set_req(5'd5);
    step();                       // edge 1
    idle_bus();
    chk("t1_busy", 32'(busy_o), 32'd1);
    chk("t1_id_full_one", id_full_o, 32'd0);
    repeat (14) step();           // edge 15
    chk("t1_no_timeout_e15", 32'(timeout_o), 32'd0);
    step();                       // edge 16
    chk("t1_timeout_e16", 32'(timeout_o), 32'd1);
    chk("t1_timeout_id", 32'(timeout_id_o), 32'd5);
    chk("t1_expired_busy", 32'(busy_o), 32'd1);

    // 2: response after two ticks -> no timeout, queue drained.
    do_reset();
    $display("txn: push id5 budget3, respond at edge 9");
    budget_i = 10'd3;
    set_req(5'd5);
    step();                       // edge 1
    idle_bus();
    repeat (7) step();            // edge 8
    set_rsp(5'd5, 1'b1);
    step();                       // edge 9
    idle_bus();
    chk("t2_busy", 32'(busy_o), 32'd0);
    chk("t2_id_full", id_full_o, 32'd0);
    repeat (11) step();           // edge 20
    chk("t2_no_timeout", 32'(timeout_o), 32'd0);
    chk("t2_no_unexp", 32'(unexp_rsp_o), 32'd0);

    // 3: fill ID2, overflow, then push+pop while full.
    do_reset();
    budget_i = 10'd500;
    $display("txn: push id2 x3");
    set_req(5'd2);
    step();
    chk("t3_full_after_1", id_full_o, 32'd0);
    step();
    chk("t3_full_after_2", id_full_o, 32'h4);
    chk("t3_no_ovf_yet", 32'(overflow_o), 32'd0);
    step();
    idle_bus();
    chk("t3_overflow", 32'(overflow_o), 32'd1);
    chk("t3_full_kept", id_full_o, 32'h4);
    $display("txn: clear");
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("t3_ovf_cleared", 32'(overflow_o), 32'd0);
    $display("txn: push+pop id2 while full");
    set_req(5'd2);
    set_rsp(5'd2, 1'b1);
    step();
    idle_bus();
    chk("t3_pp_no_ovf", 32'(overflow_o), 32'd0);
    chk("t3_pp_full", id_full_o, 32'h4);
    $display("txn: pop id2 x3");
    set_rsp(5'd2, 1'b1);
    step();
    chk("t3_pop1_full", id_full_o, 32'd0);
    chk("t3_pop1_busy", 32'(busy_o), 32'd1);
    step();
    chk("t3_pop2_busy", 32'(busy_o), 32'd0);
    chk("t3_pop2_unexp", 32'(unexp_rsp_o), 32'd0);
    step();
    idle_bus();
    chk("t3_pop3_unexp", 32'(unexp_rsp_o), 32'd1);

    // 4: beats on empty ID7.
    do_reset();
    $display("txn: R non-last id7");
    set_rsp(5'd7, 1'b0);
    step();
    chk("t4_nonlast", 32'(unexp_rsp_o), 32'd0);
    $display("txn: R last id7");
    set_rsp(5'd7, 1'b1);
    step();
    idle_bus();
    chk("t4_last", 32'(unexp_rsp_o), 32'd1);
    $display("txn: clear");
    clear_i = 1'b1;
    step();
    chk("t4_cleared", 32'(unexp_rsp_o), 32'd0);
    $display("txn: clear with R last id7");
    set_rsp(5'd7, 1'b1);
    step();
    idle_bus();
    clear_i = 1'b0;
    chk("t4_event_wins", 32'(unexp_rsp_o), 32'd1);

    // 5: IDs 9 and 3 in the same tick window, enable off for 20 cycles.
    do_reset();
    budget_i = 10'd3;
    $display("txn: push id9, push id3");
    set_req(5'd9);
    step();                       // edge 1
    set_req(5'd3);
    step();                       // edge 2
    idle_bus();
    repeat (2) step();            // edge 4 (first tick)
    $display("txn: enable off 20 cycles");
    enable_i = 1'b0;
    repeat (20) step();           // edge 24
    enable_i = 1'b1;
    chk("t5_frozen_no_to", 32'(timeout_o), 32'd0);
    repeat (11) step();           // edge 35
    chk("t5_no_timeout_e35", 32'(timeout_o), 32'd0);
    step();                       // edge 36
    chk("t5_timeout_e36", 32'(timeout_o), 32'd1);
    chk("t5_lowest_id", 32'(timeout_id_o), 32'd3);

    // 6: budget 0, async reset mid-operation.
    do_reset();
    budget_i = 10'd0;
    $display("txn: push id4, push id1 budget0");
    set_req(5'd4);
    step();                       // edge 1
    set_req(5'd1);
    step();                       // edge 2
    idle_bus();
    step();                       // edge 3
    chk("t6_no_timeout_e3", 32'(timeout_o), 32'd0);
    step();                       // edge 4
    chk("t6_timeout_b0", 32'(timeout_o), 32'd1);
    chk("t6_timeout_id", 32'(timeout_id_o), 32'd1);
    $display("txn: async reset mid-cycle");
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_async_busy", 32'(busy_o), 32'd0);
    chk("t6_async_timeout", 32'(timeout_o), 32'd0);
    chk("t6_async_id", 32'(timeout_id_o), 32'd0);
    chk("t6_async_full", id_full_o, 32'd0);
    step();
    step();
    rst_ni = 1'b1;
    $display("txn: B last id1 after release");
    set_rsp(5'd1, 1'b1);
    step();
    idle_bus();
    chk("t6_post_unexp", 32'(unexp_rsp_o), 32'd1);
    chk("t6_post_timeout", 32'(timeout_o), 32'd0);
    chk("t6_post_busy", 32'(busy_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
